// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, one-word-per-line cache controller with read refill,
// write-through (no write-allocate), flush and saturating hit/miss statistics.
module dm_cache_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              cpu_resp_hit,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 2 ** INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_t;

    state_t              state_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [DATA_W-1:0]   data_q [LINES];
    logic                hit_lat_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                resp_hit_q;
    logic                mem_valid_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [CNT_W-1:0]    hit_cnt_q;
    logic [CNT_W-1:0]    miss_cnt_q;

    logic [INDEX_W-1:0]  idx_d;
    logic [TAG_W-1:0]    tag_d;
    logic                hit_d;
    logic                refill_d;
    logic                wr_hit_d;

    // Lookup of the latched request; refill only once the memory request has been accepted
    always_comb begin
        idx_d    = addr_q[INDEX_W-1:0];
        tag_d    = addr_q[ADDR_W-1:INDEX_W];
        hit_d    = valid_q[idx_d] && (tag_q[idx_d] == tag_d);
        refill_d = (state_q == MEM_RD) && !mem_valid_q && mem_resp_valid;
        wr_hit_d = (state_q == LOOKUP) && we_q && hit_d;
    end

    assign cpu_req_ready  = rst_n && (state_q == IDLE) && !flush;
    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_rdata = resp_rdata_q;
    assign cpu_resp_hit   = resp_hit_q;
    assign mem_req_valid  = mem_valid_q;
    assign mem_req_we     = mem_we_q;
    assign mem_req_addr   = mem_addr_q;
    assign mem_req_wdata  = mem_wdata_q;
    assign hit_count      = hit_cnt_q;
    assign miss_count     = miss_cnt_q;

    // Tag/data arrays carry no reset; the valid bits alone decide whether a line is usable
    always_ff @(posedge clk) begin
        if (refill_d) begin
            data_q[idx_d] <= mem_resp_rdata;
            tag_q[idx_d]  <= tag_d;
        end else if (wr_hit_d) begin
            data_q[idx_d] <= wdata_q;
        end
    end

    // Controller FSM with registered CPU response and memory request outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            valid_q      <= '0;
            hit_lat_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        valid_q <= '0;
                    end else if (cpu_req_valid) begin
                        we_q    <= cpu_req_we;
                        addr_q  <= cpu_req_addr;
                        wdata_q <= cpu_req_wdata;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_lat_q <= hit_d;
                    if (hit_d) begin
                        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                    end else begin
                        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                    end
                    if (!we_q && hit_d) begin
                        resp_rdata_q <= data_q[idx_d];
                        resp_hit_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= we_q;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= we_q ? wdata_q : '0;
                        state_q     <= we_q ? MEM_WR : MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (mem_valid_q) begin
                        if (mem_req_ready) begin
                            mem_valid_q <= 1'b0;
                            mem_addr_q  <= '0;
                        end
                    end else if (mem_resp_valid) begin
                        valid_q[idx_d] <= 1'b1;
                        resp_rdata_q   <= mem_resp_rdata;
                        resp_hit_q     <= 1'b0;
                        resp_valid_q   <= 1'b1;
                        state_q        <= RESP;
                    end
                end
                MEM_WR: begin
                    if (mem_req_ready) begin
                        mem_valid_q  <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_wdata_q  <= '0;
                        resp_rdata_q <= '0;
                        resp_hit_q   <= hit_lat_q;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_hit_q   <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed scenarios against a small reactive memory model.
module tb_dm_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic        cpu_req_we = 1'b0;
    logic [19:0] cpu_req_addr = '0;
    logic [31:0] cpu_req_wdata = '0;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        cpu_resp_hit;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [19:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;
    logic [7:0]  hit_count;
    logic [7:0]  miss_count;

    int checks = 0;
    int errors = 0;

    logic        r_rdata_hit;
    logic [31:0] r_rdata;
    int          r_lat;
    int          r_resp_cnt;
    int          r_mreq;
    logic        r_mseen;
    logic [19:0] r_maddr;
    logic        r_mwe;
    logic [31:0] r_mwdata;
    logic        r_stable;
    logic        r_drop;
    logic        r_rdy_bad;

    dm_cache_ctrl #(.ADDR_W(20), .DATA_W(32), .INDEX_W(6), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_hit(cpu_resp_hit),
        .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // One CPU transaction from an IDLE negedge; memory accepts after rdly wait cycles and
    // answers reads one cycle after acceptance (junk=1 also drives a response on the accept cycle).
    task automatic txn(input logic we, input logic [19:0] addr, input logic [31:0] wdata,
                       input int rdly, input logic [31:0] mdata, input logic junk);
        int   wcnt = 0;
        int   post = 0;
        int   cyc;
        logic acc = 1'b0;
        logic give = 1'b0;
        logic chk_drop = 1'b0;
        r_rdata_hit = 1'b0; r_rdata = '0; r_lat = 0; r_resp_cnt = 0; r_mreq = 0; r_mseen = 1'b0;
        r_maddr = '0; r_mwe = 1'b0; r_mwdata = '0; r_stable = 1'b1; r_drop = 1'b1; r_rdy_bad = 1'b0;
        cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wdata;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
        for (int i = 0; i < 60 && post < 3; i++) begin
            mem_resp_valid = 1'b0;
            mem_resp_rdata = '0;
            if (give) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = mdata;
                give = 1'b0;
            end
            if (chk_drop && mem_req_valid) r_drop = 1'b0;
            chk_drop = 1'b0;
            if (cpu_req_ready && (r_resp_cnt == 0 || cpu_resp_valid)) r_rdy_bad = 1'b1;
            if (cpu_resp_valid) begin
                if (r_resp_cnt == 0) begin
                    r_lat = cyc;
                    r_rdata = cpu_resp_rdata;
                    r_rdata_hit = cpu_resp_hit;
                end
                r_resp_cnt++;
            end
            if (r_resp_cnt != 0) post++;
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                if (!r_mseen) begin
                    r_mseen = 1'b1; r_maddr = mem_req_addr; r_mwe = mem_req_we; r_mwdata = mem_req_wdata;
                end else if (mem_req_addr !== r_maddr || mem_req_we !== r_mwe || mem_req_wdata !== r_mwdata) begin
                    r_stable = 1'b0;
                end
                if (wcnt < rdly) begin
                    wcnt++;
                end else begin
                    mem_req_ready = 1'b1;
                    acc = 1'b1;
                    if (junk && !mem_req_we) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_rdata = 32'hBAD0BAD0;
                    end
                end
            end
            @(posedge clk);
            cyc++;
            if (acc) begin
                acc = 1'b0;
                r_mreq++;
                chk_drop = 1'b1;
                give = !r_mwe;
            end
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cpu_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b exp 0", cpu_req_ready); end
        checks++; if (cpu_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b exp 0", cpu_resp_valid); end
        checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 20'h0) begin errors++; $display("FAIL rst_mem: got %b/%h exp 0/0", mem_req_valid, mem_req_addr); end
        checks++; if (hit_count !== 8'h0 || miss_count !== 8'h0) begin errors++; $display("FAIL rst_counts: got %h/%h exp 0/0", hit_count, miss_count); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_high: got %b exp 1", cpu_req_ready); end
    endtask

    task automatic test_read_miss();
        txn(1'b0, 20'h00041, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        checks++; if (r_resp_cnt !== 1) begin errors++; $display("FAIL miss_resp_count: got %0d exp 1", r_resp_cnt); end
        checks++; if (r_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_rdata: got %h exp deadbeef", r_rdata); end
        checks++; if (r_rdata_hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b exp 0", r_rdata_hit); end
        checks++; if (r_mreq !== 1 || r_maddr !== 20'h00041 || r_mwe !== 1'b0) begin errors++; $display("FAIL miss_memreq: got n=%0d addr=%h we=%b exp 1/00041/0", r_mreq, r_maddr, r_mwe); end
        checks++; if (r_drop !== 1'b1) begin errors++; $display("FAIL miss_valid_drop: got %b exp 1", r_drop); end
        checks++; if (r_rdy_bad !== 1'b0) begin errors++; $display("FAIL miss_ready_busy: got %b exp 0", r_rdy_bad); end
        checks++; if (miss_count !== 8'd1 || hit_count !== 8'd0) begin errors++; $display("FAIL miss_counts: got %0d/%0d exp 0/1", hit_count, miss_count); end
    endtask

    task automatic test_read_hit();
        txn(1'b0, 20'h00041, 32'h0, 0, 32'h0, 1'b0);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL hit_latency: got %0d exp 2", r_lat); end
        checks++; if (r_rdata !== 32'hDEADBEEF || r_rdata_hit !== 1'b1) begin errors++; $display("FAIL hit_resp: got %h/%b exp deadbeef/1", r_rdata, r_rdata_hit); end
        checks++; if (r_mreq !== 0 || r_mseen !== 1'b0) begin errors++; $display("FAIL hit_no_mem: got %0d exp 0", r_mreq); end
        checks++; if (hit_count !== 8'd1 || r_resp_cnt !== 1) begin errors++; $display("FAIL hit_count: got %0d/%0d exp 1/1", hit_count, r_resp_cnt); end
    endtask

    task automatic test_conflict();
        txn(1'b0, 20'h00081, 32'h0, 0, 32'h12345678, 1'b1);
        checks++; if (r_rdata !== 32'h12345678 || r_rdata_hit !== 1'b0) begin errors++; $display("FAIL conflict_refill: got %h/%b exp 12345678/0", r_rdata, r_rdata_hit); end
        checks++; if (r_maddr !== 20'h00081 || miss_count !== 8'd2) begin errors++; $display("FAIL conflict_addr: got %h/%0d exp 00081/2", r_maddr, miss_count); end
        txn(1'b0, 20'h00041, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        checks++; if (r_rdata_hit !== 1'b0 || r_mreq !== 1 || miss_count !== 8'd3) begin errors++; $display("FAIL conflict_evict: got hit=%b n=%0d miss=%0d exp 0/1/3", r_rdata_hit, r_mreq, miss_count); end
        txn(1'b0, 20'h00081, 32'h0, 2, 32'h12345678, 1'b0);
        checks++; if (r_rdata !== 32'h12345678 || r_stable !== 1'b1 || miss_count !== 8'd4) begin errors++; $display("FAIL conflict_back: got %h/%b/%0d exp 12345678/1/4", r_rdata, r_stable, miss_count); end
    endtask

    task automatic test_write_hit();
        txn(1'b1, 20'h00081, 32'hCAFEF00D, 4, 32'h0, 1'b0);
        checks++; if (r_mreq !== 1 || r_mwe !== 1'b1 || r_maddr !== 20'h00081 || r_mwdata !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_memreq: got n=%0d we=%b addr=%h data=%h exp 1/1/00081/cafef00d", r_mreq, r_mwe, r_maddr, r_mwdata); end
        checks++; if (r_stable !== 1'b1) begin errors++; $display("FAIL wr_stable: got %b exp 1", r_stable); end
        checks++; if (r_resp_cnt !== 1 || r_rdata_hit !== 1'b1 || r_rdata !== 32'h0) begin errors++; $display("FAIL wr_resp: got n=%0d hit=%b rdata=%h exp 1/1/0", r_resp_cnt, r_rdata_hit, r_rdata); end
        checks++; if (r_lat !== 7 || hit_count !== 8'd2) begin errors++; $display("FAIL wr_lat_count: got %0d/%0d exp 7/2", r_lat, hit_count); end
        txn(1'b0, 20'h00081, 32'h0, 0, 32'h0, 1'b0);
        checks++; if (r_rdata !== 32'hCAFEF00D || r_rdata_hit !== 1'b1 || r_mreq !== 0) begin errors++; $display("FAIL wr_reread: got %h/%b/%0d exp cafef00d/1/0", r_rdata, r_rdata_hit, r_mreq); end
    endtask

    task automatic test_write_miss();
        txn(1'b1, 20'h000C2, 32'h55AA55AA, 0, 32'h0, 1'b0);
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL wm_latency: got %0d exp 3", r_lat); end
        checks++; if (r_rdata_hit !== 1'b0 || r_mreq !== 1 || miss_count !== 8'd5) begin errors++; $display("FAIL wm_resp: got %b/%0d/%0d exp 0/1/5", r_rdata_hit, r_mreq, miss_count); end
        txn(1'b0, 20'h000C2, 32'h0, 0, 32'h0BADF00D, 1'b0);
        checks++; if (r_rdata_hit !== 1'b0 || r_mreq !== 1 || r_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL wm_no_alloc: got %b/%0d/%h exp 0/1/0badf00d", r_rdata_hit, r_mreq, r_rdata); end
    endtask

    task automatic test_flush();
        flush = 1'b1; cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 20'h00081;
        #1;
        checks++; if (cpu_req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b exp 0", cpu_req_ready); end
        @(negedge clk);
        flush = 1'b0; cpu_req_valid = 1'b0; cpu_req_addr = '0;
        #1;
        checks++; if (cpu_req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_not_taken: got %b/%b exp 1/0", cpu_req_ready, mem_req_valid); end
        @(negedge clk);
        txn(1'b0, 20'h00081, 32'h0, 0, 32'hCAFEF00D, 1'b0);
        checks++; if (r_rdata_hit !== 1'b0 || r_mreq !== 1 || miss_count !== 8'd7) begin errors++; $display("FAIL flush_miss: got %b/%0d/%0d exp 0/1/7", r_rdata_hit, r_mreq, miss_count); end
    endtask

    task automatic test_reset_mid();
        logic got_req = 1'b0;
        logic got_resp = 1'b0;
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 20'h00100;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0; cpu_req_addr = '0;
        for (int i = 0; i < 10 && !got_req; i++) begin
            if (mem_req_valid) begin
                got_req = 1'b1;
                mem_req_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        checks++; if (got_req !== 1'b1) begin errors++; $display("FAIL rmid_memreq: got %b exp 1", got_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (hit_count !== 8'd0 || miss_count !== 8'd0) begin errors++; $display("FAIL rmid_counts: got %0d/%0d exp 0/0", hit_count, miss_count); end
        checks++; if (mem_req_valid !== 1'b0 || cpu_resp_valid !== 1'b0) begin errors++; $display("FAIL rmid_outputs: got %b/%b exp 0/0", mem_req_valid, cpu_resp_valid); end
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h11111111;
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_resp_rdata = '0; rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (cpu_resp_valid) got_resp = 1'b1;
            @(negedge clk);
        end
        checks++; if (got_resp !== 1'b0 || cpu_req_ready !== 1'b1) begin errors++; $display("FAIL rmid_no_resp: got resp=%b ready=%b exp 0/1", got_resp, cpu_req_ready); end
    endtask

    task automatic test_back_to_back();
        int          n = 0;
        logic        bad = 1'b0;
        logic        memreq = 1'b0;
        logic [7:0]  hc254 = '0;
        logic [7:0]  hc255 = '0;
        txn(1'b0, 20'hFFFFF, 32'h0, 0, 32'h5A5A5A5A, 1'b0);
        checks++; if (r_rdata !== 32'h5A5A5A5A || r_rdata_hit !== 1'b0) begin errors++; $display("FAIL top_line_fill: got %h/%b exp 5a5a5a5a/0", r_rdata, r_rdata_hit); end
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 20'hFFFFF;
        for (int i = 0; i < 1500 && n < 260; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_req_valid) memreq = 1'b1;
            if (cpu_resp_valid) begin
                n++;
                if (!cpu_resp_hit || cpu_resp_rdata !== 32'h5A5A5A5A) bad = 1'b1;
                if (n == 254) hc254 = hit_count;
                if (n == 255) hc255 = hit_count;
            end
        end
        cpu_req_valid = 1'b0; cpu_req_addr = '0;
        repeat (2) @(negedge clk);
        checks++; if (n !== 260) begin errors++; $display("FAIL b2b_resp_count: got %0d exp 260", n); end
        checks++; if (bad !== 1'b0 || memreq !== 1'b0) begin errors++; $display("FAIL b2b_hits: got bad=%b memreq=%b exp 0/0", bad, memreq); end
        checks++; if (hc254 !== 8'd254 || hc255 !== 8'd255) begin errors++; $display("FAIL sat_edge: got %0d/%0d exp 254/255", hc254, hc255); end
        checks++; if (hit_count !== 8'hFF || miss_count !== 8'd1) begin errors++; $display("FAIL sat_hold: got %0d/%0d exp 255/1", hit_count, miss_count); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_conflict();
        test_write_hit();
        test_write_miss();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Parametrised direct-mapped cache controller: CPU-side request/response port, tag/valid/data arrays, miss handling against main memory.
- Generalises the single-tag equality flag to a full lookup with valid bits, read refill, write-through, flush and hit/miss statistics.
- Sits between the CPU load/store path and the main memory model.
- One outstanding request on each side.

Parameters:
ADDR_W, 20, CPU word-address width.
DATA_W, 32, data word width.
INDEX_W, 6, index bits; 2**INDEX_W lines of one word each. Tag width TAG_W = ADDR_W-INDEX_W (must be >=1).
CNT_W, 16, width of hit/miss counters.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cpu_req_valid  in  1  CPU request present.
cpu_req_ready  out  1  controller accepts request (handshake on valid&ready).
cpu_req_we  in  1  1=write, 0=read.
cpu_req_addr  in  ADDR_W  word address; index=addr[INDEX_W-1:0], tag=addr[ADDR_W-1:INDEX_W].
cpu_req_wdata  in  DATA_W  write data.
cpu_resp_valid  out  1  one-cycle response pulse.
cpu_resp_rdata  out  DATA_W  read data; 0 for writes.
cpu_resp_hit  out  1  lookup hit for this request.
flush  in  1  invalidate all lines.
mem_req_valid  out  1  memory request.
mem_req_ready  in  1  memory accepts request.
mem_req_we  out  1  memory write.
mem_req_addr  out  ADDR_W  memory word address.
mem_req_wdata  out  DATA_W  memory write data.
mem_resp_valid  in  1  read data return.
mem_resp_rdata  in  DATA_W  read data.
hit_count  out  CNT_W  saturating hit counter.
miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all valid bits=0; counters=0.
  - All outputs 0 except cpu_req_ready, which is 1 once rst_n is high.
  - Tag and data arrays need no reset.
  - Reset mid-operation abandons the transaction; no response is issued.
- States: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- IDLE:
  - cpu_req_ready=1 unless flush=1.
  - flush=1: clears all valid bits at that edge; the request is not accepted that cycle; flush has priority over the request.
  - Otherwise valid&ready latches we/addr/wdata -> LOOKUP.
  - flush is sampled only in IDLE and ignored elsewhere.
- LOOKUP: hit = valid[idx] & (tag_array[idx]==tag).
  - hit_count increments on hit, miss_count on miss; both saturate at all-ones.
  - Read hit: rdata latched -> RESP.
  - Read miss -> MEM_RD.
  - Write, hit or miss -> MEM_WR. On write hit, data_array[idx] is updated at this edge (write-through, no write-allocate); a write miss leaves the cache unchanged.
- MEM_RD:
  - mem_req_valid=1, we=0, addr=latched addr, held stable until mem_req_ready.
  - After acceptance, wait for mem_resp_valid. On it: data_array[idx]=rdata, tag_array[idx]=tag, valid[idx]=1, latch rdata -> RESP.
  - mem_resp_valid outside the post-accept wait is ignored.
  - A mem_resp_valid in the same cycle as acceptance is not taken.
- MEM_WR:
  - mem_req_valid=1, we=1, addr and wdata held stable until mem_req_ready -> RESP.
  - No memory response is expected.
- RESP:
  - cpu_resp_valid=1 for exactly one cycle, with rdata and hit -> IDLE.
  - cpu_req_ready=0 in every state except IDLE.
- Latency from the accept edge to cpu_resp_valid high:
  - Read hit: 2 cycles.
  - Write: 3 cycles with zero-wait memory (ready=1).
  - Read miss: accept edge + LOOKUP + memory time + RESP.
- Memory outputs return to 0 outside MEM_RD/MEM_WR. mem_req_valid drops the cycle after acceptance.
- Address/index wrap: highest index (all ones) is a normal line; no special case.

Test Plan:
- Reset then read addr 0x00041: miss, mem_req addr 0x00041; memory returns 0xDEADBEEF -> resp rdata=0xDEADBEEF, hit=0, miss_count=1.
- Re-read 0x00041 -> resp 2 cycles after accept, rdata=0xDEADBEEF, hit=1, no mem_req, hit_count=1.
- Read 0x00081 (same index 1, different tag): miss, refill with 0x12345678, replaces line. Re-read 0x00041: miss again.
- Write 0x00081 data 0xCAFEF00D (hit): mem write issued with that addr/data, mem_req_ready held low 4 cycles -> req stable, one resp with hit=1. Re-read returns 0xCAFEF00D with no mem read.
- Write miss to 0x000C2, then read 0x000C2 -> read misses (no allocate).
- Flush asserted with cpu_req_valid in IDLE -> ready=0 that cycle, all valid cleared, next read of 0x00081 misses. Assert rst_n=0 during MEM_RD wait -> IDLE, no resp, counters 0. Drive 2**CNT_W hits -> hit_count saturates at all-ones.
